// File: rtl/instr_assembler.sv
// Serial instruction assembler: collects an instruction word from bus beats,
// then an immediate for I/M-type opcodes, and holds the result for decode.
module instr_assembler #(
  parameter int BUS_W   = 8,
  parameter int INSTR_W = 16,
  parameter int IMM_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               data_ready,
  input  logic [BUS_W-1:0]   serial_in,
  output logic               in_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [IMM_W-1:0]   imm,
  output logic               has_imm,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               error
);

  typedef enum logic [2:0] {
    R_TYPE  = 3'd0,
    I_TYPE  = 3'd1,
    B_TYPE  = 3'd2,
    J_TYPE  = 3'd3,
    M_TYPE  = 3'd4,
    SYS_END = 3'd5
  } opcode_t;

  typedef enum logic [1:0] {
    S_INSTR,
    S_IMM,
    S_HOLD
  } state_t;

  localparam int IB    = INSTR_W / BUS_W;
  localparam int MB    = IMM_W / BUS_W;
  localparam int MAXB  = (IB > MB) ? IB : MB;
  localparam int CNT_W = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam logic [CNT_W-1:0] IB_LAST = CNT_W'(IB - 1);
  localparam logic [CNT_W-1:0] MB_LAST = CNT_W'(MB - 1);

  function automatic logic needs_imm(input logic [2:0] op);
    return (opcode_t'(op) == I_TYPE) || (opcode_t'(op) == M_TYPE);
  endfunction

  function automatic logic is_legal(input logic [2:0] op);
    case (opcode_t'(op))
      R_TYPE, I_TYPE, B_TYPE, J_TYPE, M_TYPE, SYS_END: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [INSTR_W-1:0] r_instr;
  logic [IMM_W-1:0]   r_imm;
  logic               r_has_imm;

  logic [INSTR_W-1:0] w_instr_shift;
  logic [IMM_W-1:0]   w_imm_shift;
  logic               w_beat;
  logic               w_hs;
  logic               w_collect;
  logic               w_last_instr;
  logic               w_last_imm;

  generate
    if (IB == 1) begin : g_instr_one
      assign w_instr_shift = serial_in;
    end else begin : g_instr_multi
      assign w_instr_shift = {serial_in, r_instr[INSTR_W-1:BUS_W]};
    end
    if (MB == 1) begin : g_imm_one
      assign w_imm_shift = serial_in;
    end else begin : g_imm_multi
      assign w_imm_shift = {serial_in, r_imm[IMM_W-1:BUS_W]};
    end
  endgenerate

  assign instr_valid  = (r_state == S_HOLD);
  assign in_ready     = (r_state != S_HOLD) || instr_ready;
  assign w_beat       = data_ready && in_ready;
  assign w_hs         = instr_valid && instr_ready;
  // A beat taken during the handshake is beat 0 of the next word (count is 0 in HOLD).
  assign w_collect    = (r_state == S_INSTR) || w_hs;
  assign w_last_instr = (r_count == IB_LAST);
  assign w_last_imm   = (r_count == MB_LAST);

  assign instruction = r_instr;
  assign imm         = r_imm;
  assign has_imm     = r_has_imm;
  assign error       = instr_valid && !is_legal(r_instr[2:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_INSTR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_INSTR;
    end else if (w_collect) begin
      if (w_beat && w_last_instr)
        w_state_nxt = needs_imm(w_instr_shift[2:0]) ? S_IMM : S_HOLD;
      else
        w_state_nxt = S_INSTR;
    end else if ((r_state == S_IMM) && w_beat && w_last_imm) begin
      w_state_nxt = S_HOLD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_instr   <= '0;
      r_imm     <= '0;
      r_has_imm <= 1'b0;
    end else if (flush) begin
      r_count   <= '0;
      r_instr   <= '0;
      r_imm     <= '0;
      r_has_imm <= 1'b0;
    end else begin
      if (w_hs) begin
        r_imm     <= '0;
        r_has_imm <= 1'b0;
      end
      if (w_collect && w_beat) begin
        r_instr <= w_instr_shift;
        if (w_last_instr) begin
          r_count   <= '0;
          r_imm     <= '0;
          r_has_imm <= 1'b0;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end else if ((r_state == S_IMM) && w_beat) begin
        r_imm <= w_imm_shift;
        if (w_last_imm) begin
          r_count   <= '0;
          r_has_imm <= 1'b1;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler: a per-cycle vector table on the 8/16/16
// build, plus hand sequences for async reset and a 4/16/8 build.
module tb_instr_assembler;

  typedef struct {
    logic        fl;
    logic        dr;
    logic [7:0]  si;
    logic        ir;
    logic        ev;
    logic [15:0] ei;
    logic [15:0] em;
    logic        eh;
    logic        ee;
    logic        er;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, flush0, dr0, ir0;
  logic [7:0]  si0;
  logic        in_ready0, has_imm0, valid0, error0;
  logic [15:0] instr0, imm0;

  logic        rst1, flush1, dr1, ir1;
  logic [3:0]  si1;
  logic        in_ready1, has_imm1, valid1, error1;
  logic [15:0] instr1;
  logic [7:0]  imm1;

  int n_cmp = 0;
  int n_bad = 0;

  instr_assembler u_dut0 (
    .clk(clk), .rst(rst0), .flush(flush0), .data_ready(dr0), .serial_in(si0),
    .in_ready(in_ready0), .instruction(instr0), .imm(imm0), .has_imm(has_imm0),
    .instr_valid(valid0), .instr_ready(ir0), .error(error0)
  );

  instr_assembler #(.BUS_W(4), .INSTR_W(16), .IMM_W(8)) u_dut1 (
    .clk(clk), .rst(rst1), .flush(flush1), .data_ready(dr1), .serial_in(si1),
    .in_ready(in_ready1), .instruction(instr1), .imm(imm1), .has_imm(has_imm1),
    .instr_valid(valid1), .instr_ready(ir1), .error(error1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic dr, input logic [7:0] si,
                              input logic ir, input logic ev, input logic [15:0] ei,
                              input logic [15:0] em, input logic eh, input logic ee,
                              input logic er);
    vec_t v;
    v.fl = fl; v.dr = dr; v.si = si; v.ir = ir; v.ev = ev;
    v.ei = ei; v.em = em; v.eh = eh; v.ee = ee; v.er = er;
    return v;
  endfunction

  // beat with no valid output expected
  function automatic vec_t bt(input logic [7:0] si);
    return mk(1'b0, 1'b1, si, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic vec_t idle();
    return mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
  endfunction

  vec_t vq[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    rst0 = 1'b1; flush0 = 1'b0; dr0 = 1'b0; ir0 = 1'b1; si0 = '0;
    rst1 = 1'b1; flush1 = 1'b0; dr1 = 1'b0; ir1 = 1'b1; si1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check("reset_valid", {31'b0, valid0}, 32'h0);
    check("reset_in_ready", {31'b0, in_ready0}, 32'h1);
    check("reset_instr", {16'b0, instr0}, 32'h0);
    check("reset_imm_has_err", {imm0, 13'b0, has_imm0, error0, 1'b0}, 32'h0);
    @(posedge clk); #1;

    // R-type 16'h1230
    vq.push_back(bt(8'h30));
    vq.push_back(bt(8'h12));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 16'h1230, 16'h0000, 0, 0, 1));
    vq.push_back(idle());
    // I-type 16'hABC1, imm 16'h0001
    vq.push_back(bt(8'hC1));
    vq.push_back(bt(8'hAB));
    vq.push_back(bt(8'h01));
    vq.push_back(bt(8'h00));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 16'hABC1, 16'h0001, 1, 0, 1));
    vq.push_back(idle());
    // M-type 16'h5674 imm 16'hBEEF held 5 cycles, then J 16'h9A03 and B 16'h7702 streamed
    vq.push_back(mk(0, 1, 8'h74, 0, 0, 16'h0, 16'h0, 0, 0, 1));
    vq.push_back(mk(0, 1, 8'h56, 0, 0, 16'h0, 16'h0, 0, 0, 1));
    vq.push_back(mk(0, 1, 8'hEF, 0, 0, 16'h0, 16'h0, 0, 0, 1));
    vq.push_back(mk(0, 1, 8'hBE, 0, 0, 16'h0, 16'h0, 0, 0, 1));
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(0, 1, 8'h03, 0, 1, 16'h5674, 16'hBEEF, 1, 0, 0));
    vq.push_back(mk(0, 1, 8'h03, 1, 1, 16'h5674, 16'hBEEF, 1, 0, 1));
    vq.push_back(bt(8'h9A));
    vq.push_back(mk(0, 1, 8'h02, 1, 1, 16'h9A03, 16'h0000, 0, 0, 1));
    vq.push_back(bt(8'h77));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 16'h7702, 16'h0000, 0, 0, 1));
    // illegal opcode 6, then SYS_END 16'h4325
    vq.push_back(bt(8'h06));
    vq.push_back(bt(8'hDE));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 16'hDE06, 16'h0000, 0, 1, 1));
    vq.push_back(bt(8'h25));
    vq.push_back(bt(8'h43));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 16'h4325, 16'h0000, 0, 0, 1));
    vq.push_back(idle());
    // I-type 16'h0011 with a 3-cycle gap inside imm 16'h3C5A
    vq.push_back(bt(8'h11));
    vq.push_back(bt(8'h00));
    vq.push_back(bt(8'h5A));
    for (int k = 0; k < 3; k++) vq.push_back(idle());
    vq.push_back(bt(8'h3C));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 16'h0011, 16'h3C5A, 1, 0, 1));
    // partial word then flush (beat EE dropped), fresh word 16'h6120
    vq.push_back(bt(8'hFF));
    vq.push_back(mk(1, 1, 8'hEE, 1, 0, 16'h0, 16'h0, 0, 0, 1));
    vq.push_back(bt(8'h20));
    vq.push_back(bt(8'h61));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 16'h6120, 16'h0000, 0, 0, 1));
    vq.push_back(idle());

    for (int i = 0; i < vq.size(); i++) begin
      flush0 = vq[i].fl; dr0 = vq[i].dr; si0 = vq[i].si; ir0 = vq[i].ir;
      @(negedge clk);
      ok = (valid0 === vq[i].ev) && (in_ready0 === vq[i].er);
      if (vq[i].ev)
        ok = ok && (instr0 === vq[i].ei) && (imm0 === vq[i].em) &&
             (has_imm0 === vq[i].eh) && (error0 === vq[i].ee);
      else
        ok = ok && (error0 === 1'b0);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL vec[%0d]: got v=%b rdy=%b ins=%h imm=%h h=%b e=%b, expected v=%b rdy=%b ins=%h imm=%h h=%b e=%b",
                 i, valid0, in_ready0, instr0, imm0, has_imm0, error0,
                 vq[i].ev, vq[i].er, vq[i].ei, vq[i].em, vq[i].eh, vq[i].ee);
      end
      @(posedge clk); #1;
    end
    flush0 = 1'b0; dr0 = 1'b0; ir0 = 1'b1;

    // async reset while collecting the immediate
    dr0 = 1'b1; si0 = 8'h01; @(posedge clk); #1;
    si0 = 8'h00;             @(posedge clk); #1;
    si0 = 8'h77;             @(posedge clk); #1;
    dr0 = 1'b0;
    #2 rst0 = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, valid0}, 32'h0);
    check("async_rst_in_ready", {31'b0, in_ready0}, 32'h1);
    check("async_rst_instr", {16'b0, instr0}, 32'h0);
    check("async_rst_imm", {16'b0, imm0}, 32'h0);
    check("async_rst_has_err", {30'b0, has_imm0, error0}, 32'h0);
    @(posedge clk); #1;
    rst0 = 1'b0;
    dr0 = 1'b1; si0 = 8'h50; @(posedge clk); #1;
    si0 = 8'h55;
    @(negedge clk);
    check("post_rst_not_early", {31'b0, valid0}, 32'h0);
    @(posedge clk); #1;
    dr0 = 1'b0;
    @(negedge clk);
    check("post_rst_valid", {31'b0, valid0}, 32'h1);
    check("post_rst_instr", {16'b0, instr0}, 32'h5550);
    check("post_rst_has_imm", {31'b0, has_imm0}, 32'h0);
    @(posedge clk); #1;

    // 4-bit bus build: I-type 16'h8421 in 4 nibbles, imm 8'hC3 in 2 nibbles
    begin
      logic [3:0] nib [6];
      int early;
      nib[0] = 4'h1; nib[1] = 4'h2; nib[2] = 4'h4; nib[3] = 4'h8; nib[4] = 4'h3; nib[5] = 4'hC;
      early = 0;
      for (int k = 0; k < 6; k++) begin
        dr1 = 1'b1; si1 = nib[k];
        @(negedge clk);
        if (valid1 !== 1'b0) early++;
        @(posedge clk); #1;
      end
      dr1 = 1'b0;
      check("nib_no_early_valid", early, 0);
      @(negedge clk);
      check("nib_i_valid", {31'b0, valid1}, 32'h1);
      check("nib_i_instr", {16'b0, instr1}, 32'h8421);
      check("nib_i_imm", {24'b0, imm1}, 32'hC3);
      check("nib_i_has_err", {30'b0, has_imm1, error1}, 32'h2);
      @(posedge clk); #1;
      nib[0] = 4'h0; nib[1] = 4'hE; nib[2] = 4'h0; nib[3] = 4'hF;
      for (int k = 0; k < 4; k++) begin
        dr1 = 1'b1; si1 = nib[k];
        @(posedge clk); #1;
      end
      dr1 = 1'b0;
      @(negedge clk);
      check("nib_r_valid", {31'b0, valid1}, 32'h1);
      check("nib_r_instr", {16'b0, instr1}, 32'hF0E0);
      check("nib_r_imm_has", {23'b0, imm1, has_imm1}, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("nib_r_consumed", {31'b0, valid1}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
